// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled, single-byte holding register
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              rxclk,
  input  logic              reset,
  input  logic              rx_enable,
  input  logic              rx_in,
  input  logic              uld_rx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_empty,
  output logic              rx_frame_err,
  output logic              rx_over_run,
  output logic              rx_busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s, rx_s_d, fall;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [DATA_W-1:0]      sh;
  assign rx_s = sync[SYNC_STAGES-1];
  assign fall = rx_s_d & ~rx_s;
  // later assignments in the same cycle win: a capture overrides an unload
  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      sync         <= '1;
      rx_s_d       <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      rx_data      <= '0;
      rx_empty     <= 1'b1;
      rx_frame_err <= 1'b0;
      rx_over_run  <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], rx_in};
      rx_s_d <= rx_s;
      if (uld_rx_data) begin
        rx_empty     <= 1'b1;
        rx_frame_err <= 1'b0;
        rx_over_run  <= 1'b0;
      end
      if (!rx_enable) begin
        state   <= IDLE;
        cnt     <= '0;
        idx     <= '0;
        rx_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (fall) begin
              state   <= START;
              rx_busy <= 1'b1;
            end
          end
          START: begin
            if (cnt == HALF) begin
              cnt   <= '0;
              idx   <= '0;
              state <= rx_s ? IDLE : DATA;
              rx_busy <= ~rx_s;
            end else cnt <= cnt + CW'(1);
          end
          DATA: begin
            if (cnt == LAST) begin
              cnt <= '0;
              sh  <= {rx_s, sh[DATA_W-1:1]};
              if (idx == LAST_IDX) state <= STOP;
              else idx <= idx + IW'(1);
            end else cnt <= cnt + CW'(1);
          end
          STOP: begin
            if (cnt == LAST) begin
              cnt     <= '0;
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (!rx_s) rx_frame_err <= 1'b1;
              else if (rx_empty || uld_rx_data) begin
                rx_data  <= sh;
                rx_empty <= 1'b0;
              end else rx_over_run <= 1'b1;
            end else cnt <= cnt + CW'(1);
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level receive model
module tb_uart_rx;
  logic       rxclk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_enable = 1'b1;
  logic       rx_in = 1'b1;
  logic       uld_rx_data = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty, rx_frame_err, rx_over_run, rx_busy;
  int         total = 0;
  int         bad = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_empty = 1'b1, m_fe = 1'b0, m_or = 1'b0;

  uart_rx dut (
    .rxclk(rxclk), .reset(reset), .rx_enable(rx_enable), .rx_in(rx_in),
    .uld_rx_data(uld_rx_data), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_frame_err(rx_frame_err), .rx_over_run(rx_over_run), .rx_busy(rx_busy)
  );

  always #5 rxclk = ~rxclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data"}, 32'(rx_data), 32'(m_data));
    chk({tag, ".empty"}, 32'(rx_empty), 32'(m_empty));
    chk({tag, ".fe"}, 32'(rx_frame_err), 32'(m_fe));
    chk({tag, ".or"}, 32'(rx_over_run), 32'(m_or));
    chk({tag, ".busy"}, 32'(rx_busy), 32'd0);
  endtask

  // frame-level model: what the host sees once a frame's stop bit has been judged
  task automatic model_cap(input logic [7:0] d, input bit stop_ok, input bit uld);
    if (uld) begin
      m_empty = 1'b1;
      m_fe = 1'b0;
      m_or = 1'b0;
    end
    if (!stop_ok) m_fe = 1'b1;
    else if (m_empty) begin
      m_data = d;
      m_empty = 1'b0;
    end else m_or = 1'b1;
  endtask

  task automatic unload();
    uld_rx_data = 1'b1;
    @(negedge rxclk);
    uld_rx_data = 1'b0;
    m_empty = 1'b1;
    m_fe = 1'b0;
    m_or = 1'b0;
  endtask

  // 16 cycles per bit; the line is left at the stop-bit level
  task automatic send(input logic [7:0] d, input bit stop);
    rx_in = 1'b0;
    repeat (16) @(negedge rxclk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (16) @(negedge rxclk);
    end
    rx_in = stop;
    repeat (16) @(negedge rxclk);
  endtask

  task automatic uld_at_stop();
    repeat (154) @(negedge rxclk);
    uld_rx_data = 1'b1;
    @(negedge rxclk);
    uld_rx_data = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge rxclk);
    reset = 1'b1;
    repeat (100) @(negedge rxclk);
    chk_all("idle");

    fork
      send(8'hA5, 1'b1);
      begin
        repeat (154) @(negedge rxclk);
        chk("lat_edge153_empty", 32'(rx_empty), 32'd1);
        @(negedge rxclk);
        chk("lat_edge154_empty", 32'(rx_empty), 32'd0);
        chk("lat_edge154_data", 32'(rx_data), 32'hA5);
      end
    join
    rx_in = 1'b1;
    repeat (10) @(negedge rxclk);
    model_cap(8'hA5, 1'b1, 1'b0);
    chk_all("a5");
    unload();
    chk_all("a5_uld");

    rx_in = 1'b0;
    repeat (5) @(negedge rxclk);
    rx_in = 1'b1;
    chk("glitch_busy", 32'(rx_busy), 32'd1);
    repeat (30) @(negedge rxclk);
    chk_all("glitch");

    send(8'h3C, 1'b1);
    rx_in = 1'b1;
    model_cap(8'h3C, 1'b1, 1'b0);
    repeat (20) @(negedge rxclk);
    send(8'hC3, 1'b1);
    rx_in = 1'b1;
    model_cap(8'hC3, 1'b1, 1'b0);
    repeat (10) @(negedge rxclk);
    chk_all("overrun");
    unload();
    send(8'h3C, 1'b1);
    rx_in = 1'b1;
    model_cap(8'h3C, 1'b1, 1'b0);
    repeat (20) @(negedge rxclk);
    fork
      send(8'hC3, 1'b1);
      uld_at_stop();
    join
    rx_in = 1'b1;
    model_cap(8'hC3, 1'b1, 1'b1);
    repeat (10) @(negedge rxclk);
    chk_all("uld_at_capture");

    unload();
    send(8'h55, 1'b0);
    model_cap(8'h55, 1'b0, 1'b0);
    repeat (640) @(negedge rxclk);
    chk_all("break");
    unload();
    repeat (200) @(negedge rxclk);
    chk_all("break_once");
    rx_in = 1'b1;
    repeat (40) @(negedge rxclk);
    send(8'h81, 1'b1);
    rx_in = 1'b1;
    model_cap(8'h81, 1'b1, 1'b0);
    repeat (20) @(negedge rxclk);
    chk_all("after_break");

    unload();
    fork
      send(8'hFF, 1'b1);
      begin
        repeat (88) @(negedge rxclk);
        chk("en_busy_before", 32'(rx_busy), 32'd1);
        rx_enable = 1'b0;
        @(negedge rxclk);
        chk("en_busy_after", 32'(rx_busy), 32'd0);
      end
    join
    rx_in = 1'b1;
    repeat (20) @(negedge rxclk);
    chk_all("disabled");
    rx_enable = 1'b1;
    repeat (5) @(negedge rxclk);
    send(8'h12, 1'b1);
    rx_in = 1'b1;
    model_cap(8'h12, 1'b1, 1'b0);
    repeat (20) @(negedge rxclk);
    chk_all("reenabled");

    fork
      send(8'hC5, 1'b1);
      begin
        repeat (120) @(negedge rxclk);
        #2 reset = 1'b0;
        #1;
        chk("arst_data", 32'(rx_data), 32'd0);
        chk("arst_empty", 32'(rx_empty), 32'd1);
        chk("arst_busy", 32'(rx_busy), 32'd0);
        chk("arst_flags", 32'({rx_frame_err, rx_over_run}), 32'd0);
        @(negedge rxclk);
        reset = 1'b1;
      end
    join
    rx_in = 1'b1;
    m_data = 8'h00;
    m_empty = 1'b1;
    m_fe = 1'b0;
    m_or = 1'b0;
    repeat (20) @(negedge rxclk);
    chk_all("post_reset");

    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit st, u, uc;
      b  = 8'($urandom);
      st = $urandom_range(0, 4) != 0;
      u  = $urandom_range(0, 1) == 1;
      uc = $urandom_range(0, 3) == 0;
      if (u) unload();
      fork
        send(b, st);
        if (uc) uld_at_stop();
      join
      rx_in = 1'b1;
      model_cap(b, st, uc);
      repeat (20) @(negedge rxclk);
      chk_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
